debounce_sync: RTL and testbench

- Conditions a raw, asynchronous, possibly bouncing input into a clean, clock-synchronous level, plus single-cycle edge pulses.
- Sits directly upstream of d_flipflop: d_out drives its d input on the same clk.
- Also counts accepted rising edges, for observation in benches and on board LEDs.

---
 rtl/debounce_sync.sv | 178 +++++++++++++++++
 tb/tb_debounce_sync.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//
// Turns a raw, asynchronous, possibly bouncing input (switch or button) into a
// clean level synchronous to clk, with one-cycle pulses on each accepted edge
// and a free-running count of accepted rising edges.
//
// Processing chain:
//   d_in -> SYNC_STAGES-flop synchronizer -> s_out -> 4-state debounce FSM
//
// The FSM accepts a new level only after STABLE_CYCLES consecutive identical
// synchronized samples. Any disagreeing sample while a change is pending
// throws the pending change away.
//
// Parameters:
//   SYNC_STAGES    synchronizer depth on d_in (>= 2)
//   STABLE_CYCLES  identical samples needed before d_out changes (>= 2)
//   CNT_W          width of the rising-edge counter
//
// Ports:
//   clk       system clock, all logic on its rising edge
//   rst_n     synchronous active-low reset
//   d_in      raw asynchronous input
//   d_out     debounced, synchronized level
//   rise      one-cycle pulse on the cycle d_out goes 0->1
//   fall      one-cycle pulse on the cycle d_out goes 1->0
//   state     FSM state: 0 STABLE_LO, 1 PEND_HI, 2 STABLE_HI, 3 PEND_LO
//   edge_cnt  number of accepted rising edges, wraps silently
//
// Every output comes straight from a flop; d_in reaches nothing except the
// first synchronizer stage.
// -----------------------------------------------------------------------------
module debounce_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             d_in,
   output logic             d_out,
   output logic             rise,
   output logic             fall,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] edge_cnt
);

   // Wide enough to hold STABLE_CYCLES itself.
   localparam int CW = $clog2(STABLE_CYCLES + 1);

   // Counter value at which the final confirming sample completes a change:
   // the pending state is entered with cnt = 1 on the first new-level sample,
   // so the STABLE_CYCLES-th sample arrives while cnt = STABLE_CYCLES-1.
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } state_t;

   // --------------------------------------------------------------------------
   // Synchronizer
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_out;

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the values from before the edge, regardless of block order.
   // The reset is tested inside the clocked block, so it only acts on an edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      end
   end

   assign s_out = sync_q[SYNC_STAGES-1];

   // --------------------------------------------------------------------------
   // Debounce FSM: state and registered outputs
   // --------------------------------------------------------------------------
   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_d;
   logic            d_out_d;
   logic            rise_d;
   logic            fall_d;
   logic [CNT_W-1:0] edge_cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= STABLE_LO;
         cnt      <= '0;
         d_out    <= 1'b0;
         rise     <= 1'b0;
         fall     <= 1'b0;
         edge_cnt <= '0;
      end else begin
         state_q  <= state_d;
         cnt      <= cnt_d;
         d_out    <= d_out_d;
         rise     <= rise_d;
         fall     <= fall_d;
         edge_cnt <= edge_cnt_d;
      end
   end

   // NOTE: every signal driven here gets a default before the case statement,
   // so no path leaves one unassigned and no latch is inferred. The pulse
   // defaults of 0 are also what makes rise/fall last exactly one cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt;
      d_out_d    = d_out;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      edge_cnt_d = edge_cnt;

      case (state_q)
         STABLE_LO: begin
            if (s_out) begin
               state_d = PEND_HI;
               cnt_d   = CNT_ONE;
            end
         end

         PEND_HI: begin
            if (!s_out) begin
               // Bounce: level did not hold long enough.
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt == CNT_LAST) begin
               state_d    = STABLE_HI;
               cnt_d      = '0;
               d_out_d    = 1'b1;
               rise_d     = 1'b1;
               edge_cnt_d = edge_cnt + CNT_W'(1);
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end

         STABLE_HI: begin
            if (!s_out) begin
               state_d = PEND_LO;
               cnt_d   = CNT_ONE;
            end
         end

         PEND_LO: begin
            if (s_out) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               d_out_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end

         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//
// Self-checking bench for debounce_sync with default parameters. A table of
// per-edge {inputs, expected outputs} records covers reset, clean edges and
// bounce rejection; hand-written sequences cover asynchronous fast toggling,
// reset while a change is pending, and edge_cnt wrap-around. Expected records
// go through a queue: pushed when the inputs are driven, popped and compared
// after the clock edge that produces the outputs.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

   localparam int CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic             d_in;
   logic             d_out;
   logic             rise;
   logic             fall;
   logic [1:0]       state;
   logic [CNT_W-1:0] edge_cnt;

   debounce_sync #(
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(4),
      .CNT_W        (CNT_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_in    (d_in),
      .d_out   (d_out),
      .rise    (rise),
      .fall    (fall),
      .state   (state),
      .edge_cnt(edge_cnt)
   );

   initial clk = 1'b0;
   always #3 clk = ~clk;

   typedef struct {
      logic             rst_n;
      logic             d_in;
      logic             exp_d_out;
      logic             exp_rise;
      logic             exp_fall;
      logic [1:0]       exp_state;
      logic [CNT_W-1:0] exp_edge_cnt;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Append n identical records to the vector table.
   task automatic add_run(input int n, input logic r, input logic d,
                          input logic e_d, input logic e_r, input logic e_f,
                          input logic [1:0] e_s, input logic [CNT_W-1:0] e_c);
      vec_t v;
      v.rst_n = r; v.d_in = d; v.exp_d_out = e_d; v.exp_rise = e_r;
      v.exp_fall = e_f; v.exp_state = e_s; v.exp_edge_cnt = e_c;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   // Drive one record away from the active edge, then compare the outputs of
   // the edge it feeds.
   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clk);
      rst_n = v.rst_n;
      d_in  = v.d_in;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("d_out",    {31'd0, d_out}, {31'd0, e.exp_d_out});
         check("rise",     {31'd0, rise},  {31'd0, e.exp_rise});
         check("fall",     {31'd0, fall},  {31'd0, e.exp_fall});
         check("state",    {30'd0, state}, {30'd0, e.exp_state});
         check("edge_cnt", {24'd0, edge_cnt}, {24'd0, e.exp_edge_cnt});
      end
   endtask

   task automatic step1(input logic r, input logic d, input logic e_d, input logic e_r,
                        input logic e_f, input logic [1:0] e_s, input logic [CNT_W-1:0] e_c);
      vec_t v;
      v.rst_n = r; v.d_in = d; v.exp_d_out = e_d; v.exp_rise = e_r;
      v.exp_fall = e_f; v.exp_state = e_s; v.exp_edge_cnt = e_c;
      step(v);
   endtask

   // Watchdog: the bench uses only fixed cycle counts, this guards anything else.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [CNT_W-1:0] exp_cnt;
      int               n_rise;
      int               n_fall;
      int               n_pulse;

      rst_n = 1'b0;
      d_in  = 1'b1;

      // ---- table: reset, release with d_in=1, clean fall/rise, bounce ----
      //        n  rst d   d_out rise fall state cnt
      add_run(3, 0, 1,  0, 0, 0, 2'd0, 8'd0);   // held in reset
      add_run(2, 1, 1,  0, 0, 0, 2'd0, 8'd0);   // synchronizer filling
      add_run(3, 1, 1,  0, 0, 0, 2'd1, 8'd0);   // PEND_HI
      add_run(1, 1, 1,  1, 1, 0, 2'd2, 8'd1);   // accepted at edge 6
      add_run(1, 1, 1,  1, 0, 0, 2'd2, 8'd1);   // rise lasts one cycle
      // clean fall, 8 cycles
      add_run(2, 1, 0,  1, 0, 0, 2'd2, 8'd1);
      add_run(3, 1, 0,  1, 0, 0, 2'd3, 8'd1);
      add_run(1, 1, 0,  0, 0, 1, 2'd0, 8'd1);
      add_run(2, 1, 0,  0, 0, 0, 2'd0, 8'd1);
      // clean rise, 10 cycles
      add_run(2, 1, 1,  0, 0, 0, 2'd0, 8'd1);
      add_run(3, 1, 1,  0, 0, 0, 2'd1, 8'd1);
      add_run(1, 1, 1,  1, 1, 0, 2'd2, 8'd2);
      add_run(4, 1, 1,  1, 0, 0, 2'd2, 8'd2);
      // clean fall back to STABLE_LO
      add_run(2, 1, 0,  1, 0, 0, 2'd2, 8'd2);
      add_run(3, 1, 0,  1, 0, 0, 2'd3, 8'd2);
      add_run(1, 1, 0,  0, 0, 1, 2'd0, 8'd2);
      add_run(2, 1, 0,  0, 0, 0, 2'd0, 8'd2);
      // bounce: high 3, low 1, high 2, then low
      add_run(2, 1, 1,  0, 0, 0, 2'd0, 8'd2);
      add_run(1, 1, 1,  0, 0, 0, 2'd1, 8'd2);
      add_run(1, 1, 0,  0, 0, 0, 2'd1, 8'd2);
      add_run(1, 1, 1,  0, 0, 0, 2'd1, 8'd2);
      add_run(1, 1, 1,  0, 0, 0, 2'd0, 8'd2);   // short high rejected
      add_run(1, 1, 0,  0, 0, 0, 2'd1, 8'd2);
      add_run(1, 1, 0,  0, 0, 0, 2'd1, 8'd2);
      add_run(2, 1, 0,  0, 0, 0, 2'd0, 8'd2);   // rejected again

      foreach (vecs[i]) step(vecs[i]);

      // ---- fast asynchronous toggling: d_in flips every 5 time units ----
      fork
         begin
            repeat (40) begin
               #5 d_in = ~d_in;
            end
         end
         begin
            repeat (33) begin
               @(posedge clk);
               #1;
               check("toggle_d_out", {31'd0, d_out}, 32'd0);
               check("toggle_pulse", {30'd0, rise, fall}, 32'd0);
            end
         end
      join
      @(negedge clk);
      d_in = 1'b0;
      repeat (4) @(posedge clk);
      step1(1, 0,  0, 0, 0, 2'd0, 8'd2);
      step1(1, 0,  0, 0, 0, 2'd0, 8'd2);

      // ---- reset while PEND_HI with cnt=2 ----
      step1(1, 1,  0, 0, 0, 2'd0, 8'd2);
      step1(1, 1,  0, 0, 0, 2'd0, 8'd2);
      step1(1, 1,  0, 0, 0, 2'd1, 8'd2);
      step1(1, 1,  0, 0, 0, 2'd1, 8'd2);
      check("pend_cnt", {29'd0, dut.cnt}, 32'd2);
      step1(0, 1,  0, 0, 0, 2'd0, 8'd0);
      check("reset_cnt", {29'd0, dut.cnt}, 32'd0);
      // release with d_in held high: full latency again, no pulse right after reset
      step1(1, 1,  0, 0, 0, 2'd0, 8'd0);
      step1(1, 1,  0, 0, 0, 2'd0, 8'd0);
      step1(1, 1,  0, 0, 0, 2'd1, 8'd0);
      step1(1, 1,  0, 0, 0, 2'd1, 8'd0);
      step1(1, 1,  0, 0, 0, 2'd1, 8'd0);
      step1(1, 1,  1, 1, 0, 2'd2, 8'd1);
      step1(1, 1,  1, 0, 0, 2'd2, 8'd1);

      // ---- edge_cnt wrap: 256 accepted rising edges from a fresh reset ----
      step1(0, 0,  0, 0, 0, 2'd0, 8'd0);
      step1(0, 0,  0, 0, 0, 2'd0, 8'd0);
      exp_cnt = '0;
      n_rise  = 0;
      n_fall  = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         rst_n = 1'b1;
         d_in  = 1'b1;
         n_pulse = 0;
         repeat (7) begin
            @(posedge clk);
            #1;
            if (rise) n_pulse++;
         end
         n_rise += n_pulse;
         exp_cnt = exp_cnt + 8'd1;
         if (i >= 253 || i < 2) check("wrap_edge_cnt", {24'd0, edge_cnt}, {24'd0, exp_cnt});
         @(negedge clk);
         d_in = 1'b0;
         repeat (7) begin
            @(posedge clk);
            #1;
            if (fall) n_fall++;
         end
      end
      check("wrap_final_zero", {24'd0, edge_cnt}, 32'd0);
      check("wrap_rise_pulses", n_rise, 256);
      check("wrap_fall_pulses", n_fall, 256);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
